// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker: a feed-forward Fibonacci LFSR predicts each
// received bit from earlier received bits, with lock tracking and a saturating error count.
module lfsr_prbs_check #(
    parameter int unsigned           LFSR_WIDTH    = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
    parameter bit                    LFSR_INVERT   = 1'b1,
    parameter bit                    REVERSE       = 1'b0,
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           LOCK_COUNT    = 16,
    parameter int unsigned           UNLOCK_ERRORS = 4,
    parameter int unsigned           ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    input  logic                     clear_count,
    output logic                     locked,
    output logic [DATA_WIDTH-1:0]    error_bits,
    output logic                     error_valid,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    localparam int unsigned CLEAN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ERUN_W  = $clog2(UNLOCK_ERRORS + 1);
    localparam int unsigned POP_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SUM_W   = ((ERR_CNT_WIDTH > POP_W) ? ERR_CNT_WIDTH : POP_W) + 1;

    // Prediction taps: the last stage plus every stage j-1 for which POLY bit j is set
    localparam logic [LFSR_WIDTH-1:0] TAP_MASK = {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]};

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic                     locked_q, locked_d;
    logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [CLEAN_W-1:0]       clean_run_q, clean_run_d;
    logic [ERUN_W-1:0]        err_run_q, err_run_d;
    logic [DATA_WIDTH-1:0]    error_bits_q, error_bits_d;
    logic                     error_valid_q, error_valid_d;
    logic [ERR_CNT_WIDTH-1:0] error_count_q, error_count_d;

    logic [LFSR_WIDTH-1:0]    chain [DATA_WIDTH+1];
    logic [DATA_WIDTH-1:0]    err_raw;
    logic [DATA_WIDTH-1:0]    err;
    logic                     word_err;
    logic [POP_W-1:0]         pop;
    logic [SUM_W-1:0]         cnt_sum;
    logic [ERR_CNT_WIDTH-1:0] cnt_sat;

    // Bit-serial unroll: each received bit is checked, then shifted into the state
    assign chain[0] = lfsr_q;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        localparam int unsigned IDX = REVERSE ? i : (DATA_WIDTH - 1 - i);
        assign err_raw[IDX]  = data_in[IDX] ^ (^(chain[i] & TAP_MASK));
        assign chain[i+1]    = {chain[i][LFSR_WIDTH-2:0], data_in[IDX]};
    end

    assign err      = err_raw ^ {DATA_WIDTH{LFSR_INVERT}};
    assign word_err = |err;

    always_comb begin : popcount
        logic [DATA_WIDTH-1:0] rem;
        rem = err;
        pop = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            pop = pop + POP_W'(rem[0]);
            rem = rem >> 1;
        end
    end

    // Saturating accumulate: any carry above the counter width pins it at all-ones
    assign cnt_sum = SUM_W'(error_count_q) + SUM_W'(pop);
    assign cnt_sat = (|cnt_sum[SUM_W-1:ERR_CNT_WIDTH]) ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];

    always_comb begin : next_state
        state_d       = state_q;
        locked_d      = locked_q;
        lfsr_d        = lfsr_q;
        clean_run_d   = clean_run_q;
        err_run_d     = err_run_q;
        error_bits_d  = error_bits_q;
        error_valid_d = 1'b0;
        error_count_d = error_count_q;

        if (data_in_valid) begin
            lfsr_d        = chain[DATA_WIDTH];
            error_bits_d  = err;
            error_valid_d = 1'b1;
            if (state_q == ST_LOCKED) begin
                error_count_d = cnt_sat;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (word_err) begin
                        clean_run_d = '0;
                    end else if (clean_run_q == CLEAN_W'(LOCK_COUNT - 1)) begin
                        state_d     = ST_LOCKED;
                        locked_d    = 1'b1;
                        clean_run_d = '0;
                        err_run_d   = '0;
                    end else begin
                        clean_run_d = clean_run_q + CLEAN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!word_err) begin
                        err_run_d = '0;
                    end else if (err_run_q == ERUN_W'(UNLOCK_ERRORS - 1)) begin
                        state_d     = ST_SEARCH;
                        locked_d    = 1'b0;
                        clean_run_d = '0;
                        err_run_d   = '0;
                    end else begin
                        err_run_d = err_run_q + ERUN_W'(1);
                    end
                end
                default: begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear wins over accumulation; that word's errors are dropped
        if (clear_count) begin
            error_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            locked_q      <= 1'b0;
            lfsr_q        <= '0;
            clean_run_q   <= '0;
            err_run_q     <= '0;
            error_bits_q  <= '0;
            error_valid_q <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            locked_q      <= locked_d;
            lfsr_q        <= lfsr_d;
            clean_run_q   <= clean_run_d;
            err_run_q     <= err_run_d;
            error_bits_q  <= error_bits_d;
            error_valid_q <= error_valid_d;
            error_count_q <= error_count_d;
        end
    end

    assign locked      = locked_q;
    assign error_bits  = error_bits_q;
    assign error_valid = error_valid_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Bench for lfsr_prbs_check: PRBS7 byte checker (4-bit counter) plus a pair of
// 32-bit LSB-first PRBS31 checkers, one expecting inversion and one not.
module tb_lfsr_prbs_check;

    localparam int unsigned N_VEC = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  d7  = '0;
    logic        v7  = 1'b0;
    logic        c7  = 1'b0;
    logic        l7;
    logic [7:0]  eb7;
    logic        ev7;
    logic [3:0]  cnt7;

    logic [31:0] d31 = '0;
    logic        v31 = 1'b0;
    logic        c31 = 1'b0;
    logic        l31i, l31n;
    logic [31:0] eb31i, eb31n;
    logic        ev31i, ev31n;
    logic [31:0] cnt31i, cnt31n;

    lfsr_prbs_check #(
        .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_INVERT(1'b0), .REVERSE(1'b0),
        .DATA_WIDTH(8), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .ERR_CNT_WIDTH(4)
    ) u_prbs7 (
        .clk(clk), .rst(rst), .data_in(d7), .data_in_valid(v7), .clear_count(c7),
        .locked(l7), .error_bits(eb7), .error_valid(ev7), .error_count(cnt7)
    );

    lfsr_prbs_check #(
        .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_INVERT(1'b1), .REVERSE(1'b1),
        .DATA_WIDTH(32), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .ERR_CNT_WIDTH(32)
    ) u_prbs31_inv (
        .clk(clk), .rst(rst), .data_in(d31), .data_in_valid(v31), .clear_count(c31),
        .locked(l31i), .error_bits(eb31i), .error_valid(ev31i), .error_count(cnt31i)
    );

    lfsr_prbs_check #(
        .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_INVERT(1'b0), .REVERSE(1'b1),
        .DATA_WIDTH(32), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .ERR_CNT_WIDTH(32)
    ) u_prbs31_plain (
        .clk(clk), .rst(rst), .data_in(d31), .data_in_valid(v31), .clear_count(c31),
        .locked(l31n), .error_bits(eb31n), .error_valid(ev31n), .error_count(cnt31n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: transmit generators and received-bit histories
    logic [6:0]  g7;
    logic [30:0] g31;
    bit          rx7[$];
    bit          rx31[$];

    typedef struct packed {
        logic [7:0] err;
        logic       lk;
        logic [3:0] cnt;
    } exp7_t;

    exp7_t       sb7[$];
    logic [31:0] sb31[$];

    bit     m7_lk, m31_lk;
    int     m7_clean, m7_erun, m31_clean, m31_erun;
    longint m7_cnt, m31_cnt;
    logic [7:0] last_err7;
    int     n31;

    typedef struct packed {
        int         words;
        bit         toggle;
        logic [7:0] flip;
        int         period;
        bit         clr;
        logic       exp_lk;
        int         exp_cnt;
    } vec7_t;

    vec7_t tbl [N_VEC];
    string tbl_name [N_VEC];

    function automatic bit rx7_past(input int k);
        if (rx7.size() < k) return 1'b0;
        return rx7[rx7.size() - k];
    endfunction

    function automatic bit rx31_past(input int k);
        if (rx31.size() < k) return 1'b0;
        return rx31[rx31.size() - k];
    endfunction

    // Lock/unlock and counting behaviour at word granularity
    task automatic fsm_step(input logic [31:0] err, input bit clr, input longint sat_max,
                            inout bit lk, inout int clean, inout int erun, inout longint cnt);
        if (clr) cnt = 0;
        else if (lk) begin
            cnt = cnt + $countones(err);
            if (cnt > sat_max) cnt = sat_max;
        end
        if (!lk) begin
            if (err != 0) clean = 0;
            else begin
                clean++;
                if (clean == 16) begin lk = 1'b1; clean = 0; erun = 0; end
            end
        end else begin
            if (err != 0) begin
                erun++;
                if (erun == 4) begin lk = 1'b0; clean = 0; erun = 0; end
            end else erun = 0;
        end
    endtask

    task automatic step7(input bit v, input logic [7:0] flip, input bit clr);
        logic [7:0] w;
        logic [7:0] e;
        logic       b;
        exp7_t      x;
        @(negedge clk);
        if (v) begin
            for (int i = 0; i < 8; i++) begin
                b = g7[6] ^ g7[5];
                g7 = {g7[5:0], b};
                w[7-i] = b;
            end
            w = w ^ flip;
            for (int i = 0; i < 8; i++) begin
                e[7-i] = w[7-i] ^ rx7_past(7) ^ rx7_past(6);
                rx7.push_back(w[7-i]);
            end
            while (rx7.size() > 32) void'(rx7.pop_front());
            fsm_step({24'h0, e}, clr, 64'd15, m7_lk, m7_clean, m7_erun, m7_cnt);
            x.err = e;
            x.lk  = m7_lk;
            x.cnt = 4'(m7_cnt);
            sb7.push_back(x);
            d7 = w;
        end else begin
            if (clr) m7_cnt = 0;
            d7 = 8'($urandom);
        end
        v7 = v;
        c7 = clr;
        @(posedge clk);
        #1;
        v7 = 1'b0;
        c7 = 1'b0;
        check("error_valid7", 64'(ev7), 64'(v));
        if (v) begin
            x = sb7.pop_front();
            check("error_bits7", 64'(eb7), 64'(x.err));
            check("locked7", 64'(l7), 64'(x.lk));
            check("error_count7", 64'(cnt7), 64'(x.cnt));
            last_err7 = x.err;
        end else begin
            check("error_bits7_hold", 64'(eb7), 64'(last_err7));
            check("locked7_idle", 64'(l7), 64'(m7_lk));
            check("error_count7_idle", 64'(cnt7), 64'(m7_cnt[3:0]));
        end
    endtask

    task automatic step31();
        logic [31:0] w;
        logic [31:0] e;
        logic        b;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            b = g31[30] ^ g31[27];
            g31 = {g31[29:0], b};
            w[i] = ~b;
            e[i] = w[i] ^ rx31_past(31) ^ rx31_past(28) ^ 1'b1;
            rx31.push_back(w[i]);
        end
        while (rx31.size() > 64) void'(rx31.pop_front());
        fsm_step(e, 1'b0, 64'hFFFF_FFFF, m31_lk, m31_clean, m31_erun, m31_cnt);
        sb31.push_back(e);
        d31 = w;
        v31 = 1'b1;
        @(posedge clk);
        #1;
        v31 = 1'b0;
        n31++;
        e = sb31.pop_front();
        check("error_bits31", 64'(eb31i), 64'(e));
        check("error_valid31", 64'(ev31i), 64'd1);
        check("locked31", 64'(l31i), 64'(m31_lk));
        check("error_count31", 64'(cnt31i), 64'(m31_cnt[31:0]));
        check("locked31_plain", 64'(l31n), 64'd0);
        check("error_count31_plain", 64'(cnt31n), 64'd0);
        if (n31 > 1) check("error_bits31_plain", 64'(eb31n), 64'hFFFF_FFFF);
    endtask

    task automatic reset_models();
        rx7.delete();
        rx31.delete();
        m7_lk = 1'b0;  m7_clean = 0;  m7_erun = 0;  m7_cnt = 0;
        m31_lk = 1'b0; m31_clean = 0; m31_erun = 0; m31_cnt = 0;
        last_err7 = '0;
        n31 = 0;
        g7  = 7'h7F;
        g31 = 31'h1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16,  1'b0, 8'h00, 1, 1'b0, 1'b0, 0};  tbl_name[0]  = "search16";
        tbl[1]  = '{1,   1'b0, 8'h00, 1, 1'b0, 1'b1, 0};  tbl_name[1]  = "lock17";
        tbl[2]  = '{983, 1'b0, 8'h00, 1, 1'b0, 1'b1, 0};  tbl_name[2]  = "run1000";
        tbl[3]  = '{2,   1'b0, 8'h08, 2, 1'b0, 1'b1, 3};  tbl_name[3]  = "flip_bit3";
        tbl[4]  = '{4,   1'b0, 8'h00, 1, 1'b0, 1'b1, 3};  tbl_name[4]  = "settle";
        tbl[5]  = '{1,   1'b0, 8'h80, 1, 1'b1, 1'b1, 0};  tbl_name[5]  = "clear_same";
        tbl[6]  = '{2,   1'b0, 8'h00, 1, 1'b0, 1'b1, 0};  tbl_name[6]  = "clean";
        tbl[7]  = '{4,   1'b0, 8'h01, 1, 1'b0, 1'b0, 10}; tbl_name[7]  = "unlock";
        tbl[8]  = '{1,   1'b0, 8'h00, 1, 1'b0, 1'b0, 10}; tbl_name[8]  = "resync";
        tbl[9]  = '{15,  1'b1, 8'h00, 1, 1'b0, 1'b0, 10}; tbl_name[9]  = "relock15";
        tbl[10] = '{1,   1'b0, 8'h00, 1, 1'b0, 1'b1, 10}; tbl_name[10] = "relock16";
        tbl[11] = '{1,   1'b0, 8'h00, 1, 1'b1, 1'b1, 0};  tbl_name[11] = "clear";
        tbl[12] = '{40,  1'b0, 8'h80, 2, 1'b0, 1'b1, 15}; tbl_name[12] = "saturate";

        reset_models();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_locked", 64'(l7), 64'd0);
        check("reset_error_valid", 64'(ev7), 64'd0);
        check("reset_error_bits", 64'(eb7), 64'd0);
        check("reset_error_count", 64'(cnt7), 64'd0);
        rst = 1'b0;

        for (int t = 0; t < N_VEC; t++) begin
            for (int k = 0; k < tbl[t].words; k++) begin
                step7(1'b1, ((k % tbl[t].period) == 0) ? tbl[t].flip : 8'h00,
                      tbl[t].clr && (k == 0));
                if (tbl[t].toggle) step7(1'b0, 8'h00, 1'b0);
            end
            check({tbl_name[t], "_locked"}, 64'(l7), 64'(tbl[t].exp_lk));
            check({tbl_name[t], "_count"}, 64'(cnt7), 64'(tbl[t].exp_cnt));
        end

        // Asynchronous reset while locked with a nonzero count
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_locked", 64'(l7), 64'd0);
        check("async_rst_count", 64'(cnt7), 64'd0);
        check("async_rst_error_bits", 64'(eb7), 64'd0);
        check("async_rst_error_valid", 64'(ev7), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_models();

        // Same lock point counted in valid words with idle cycles in between
        for (int k = 0; k < 16; k++) begin
            step7(1'b1, 8'h00, 1'b0);
            step7(1'b0, 8'h00, 1'b0);
        end
        check("toggle_search16", 64'(l7), 64'd0);
        step7(1'b1, 8'h00, 1'b0);
        check("toggle_lock17", 64'(l7), 64'd1);
        check("toggle_count", 64'(cnt7), 64'd0);

        // Inverted PRBS31, LSB first
        for (int k = 0; k < 16; k++) step31();
        check("prbs31_search16", 64'(l31i), 64'd0);
        step31();
        check("prbs31_lock17", 64'(l31i), 64'd1);
        for (int k = 0; k < 23; k++) step31();
        check("prbs31_count", 64'(cnt31i), 64'd0);
        check("prbs31_plain_never_locks", 64'(l31n), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_check.md
Name: lfsr_prbs_check

Overview:
- Self-synchronising PRBS checker for the receive side of a link driven by the team's parallel LFSR PRBS generator.
- Consumes DATA_WIDTH received bits per valid cycle and predicts each bit from previously received bits using a feed-forward LFSR.
- Flags per-bit errors, runs a lock/unlock state machine, and accumulates a saturating bit-error count.

Parameters:
- LFSR_WIDTH, 31, PRBS register length.
- LFSR_POLY, 31'h10000001, polynomial with the top term suppressed (same encoding as the generator).
- LFSR_INVERT, 1, expected stream is inverted (1 for PRBS15/23/29/31, 0 otherwise).
- REVERSE, 0, bit order: 0 = MSB first, 1 = LSB first.
- DATA_WIDTH, 8, received bits per word.
- LOCK_COUNT, 16, consecutive error-free words required to lock.
- UNLOCK_ERRORS, 4, consecutive errored words required to drop lock.
- ERR_CNT_WIDTH, 32, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- data_in  in  DATA_WIDTH  received PRBS word.
- data_in_valid  in  1  qualifies data_in.
- clear_count  in  1  synchronous clear of error_count.
- locked  out  1  checker locked to the stream.
- error_bits  out  DATA_WIDTH  per-bit mismatch for the last valid word.
- error_valid  out  1  qualifies error_bits.
- error_count  out  ERR_CNT_WIDTH  saturating count of bit errors seen while locked.

Behaviour:
- Reset values: locked=0, error_bits=0, error_valid=0, error_count=0, internal LFSR state=0, FSM=SEARCH, run counters=0. Reset is asynchronous and active-high.
- Core is a Fibonacci feed-forward LFSR.
  - Feed-forward output for word w: err_raw = data_in XOR (prediction from state).
  - Next state = previous state shifted by DATA_WIDTH with the received bits shifted in.
  - REVERSE selects MSB-first or LSB-first bit order, exactly as in the generator.
  - Expected bits: err = err_raw XOR {DATA_WIDTH{LFSR_INVERT}}.
- A cycle without data_in_valid holds the state register, FSM, counters and error_count. error_valid is 0 on the next cycle, and error_bits holds its last value.
- Latency: error_bits and error_valid are registered and appear 1 cycle after the valid input word. locked and error_count update on the same edge.
- Word flag: word_err = |err.
- FSM SEARCH:
  - Clean valid word: clean_run++.
  - Errored word: clean_run=0.
  - When clean_run reaches LOCK_COUNT, go to LOCKED, set locked=1 and clear both run counters.
- FSM LOCKED:
  - Errored word: err_run++.
  - Clean word: err_run=0.
  - When err_run reaches UNLOCK_ERRORS, go to SEARCH, set locked=0 and clear both run counters.
- Error counting: error_count += popcount(err) for every valid word processed while the FSM is LOCKED, including the word that causes unlock. Nothing is counted in SEARCH. The counter saturates at all-ones and never wraps.
- clear_count sets error_count=0 and has priority over accumulation in the same cycle; that cycle's errors are dropped. It does not affect FSM, lock or LFSR state.
- The LFSR state is not reset on unlock; the core self-resynchronises after LFSR_WIDTH clean bits.
- Up to ceil(LFSR_WIDTH/DATA_WIDTH) words after reset may show errors. These are SEARCH-phase errors and are not counted.
- Reset asserted mid-operation returns all registers to reset values immediately.

Test Plan:
- Reset: assert rst mid-stream with locked=1 and error_count=5 -> all outputs 0 asynchronously, FSM=SEARCH.
- Lock (LFSR_WIDTH=7, LFSR_POLY=7'h41, LFSR_INVERT=0, DATA_WIDTH=8): continuous clean PRBS7 words -> locked rises the edge after the 16th consecutive clean word; error_count stays 0 over 1000 words. Repeat with data_in_valid toggling 50% -> identical lock point counted in valid words, error_valid low on idle cycles.
- Single-bit flip: while locked, invert bit 3 of one word -> exactly 3 error bits across that and the following word (positions +0, +6, +7 bits); error_count=3; locked stays 1.
- Unlock: while locked, flip bit 0 of each of 4 consecutive words -> locked falls the edge after the 4th word. error_count increments by the errors of all 4 words. Resuming a clean stream -> relock after 16 clean words.
- Counter: clear_count asserted on the same cycle as an errored locked word -> error_count=0 afterwards. With ERR_CNT_WIDTH=4, inject 20 single-bit errors while locked (with no unlock) -> error_count sticks at 15.
- Inverted stream (LFSR_WIDTH=31, LFSR_POLY=31'h10000001, LFSR_INVERT=1, REVERSE=1, DATA_WIDTH=32): clean inverted PRBS31 words -> lock after 16 words with zero counted errors. The same stream with LFSR_INVERT=0 -> every bit errors and the checker never locks.
